// File: rtl/servo_pkg.sv
// servo_pkg: servo timing constants at 100 MHz and the decoder FSM state type,
// shared by the servo PWM generator and decoder.
package servo_pkg;
    localparam int MIN_PULSE   = 50000;
    localparam int MAX_PULSE   = 250000;
    localparam int CYC_PER_DEG = 1111;
    localparam int MIN_PERIOD  = 1900000;
    localparam int MAX_PERIOD  = 2100000;
    localparam int TIMEOUT     = 2500000;
    localparam int MAX_ANGLE   = 180;
    typedef enum logic [1:0] {IDLE, HIGH, DIV, VALID} state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-FF synchronizer for an asynchronous pin with single-cycle
// rise/fall pulses from one extra edge-detect register.
module pwm_sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_d;
    always_ff @(posedge clk) begin
        if (!clr) {r_s1, r_s2, r_d} <= 3'b000;
        else {r_s1, r_s2, r_d} <= {i_async, r_s1, r_s2};
    end
    assign o_rise = r_s2 & ~r_d;
    assign o_fall = ~r_s2 & r_d;
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo PWM high width and frame period, converts
// the width to an angle 0..180 by repeated subtraction.
module servo_pwm_decoder #(
    parameter int MIN_PULSE   = servo_pkg::MIN_PULSE,
    parameter int MAX_PULSE   = servo_pkg::MAX_PULSE,
    parameter int CYC_PER_DEG = servo_pkg::CYC_PER_DEG,
    parameter int MIN_PERIOD  = servo_pkg::MIN_PERIOD,
    parameter int MAX_PERIOD  = servo_pkg::MAX_PERIOD,
    parameter int TIMEOUT     = servo_pkg::TIMEOUT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pwm_in,
    output logic [8:0]  angle,
    output logic        angle_valid,
    output logic [19:0] pulse_width,
    output logic        width_err,
    output logic        period_err,
    output logic        signal_lost,
    output logic        busy
);
    import servo_pkg::*;
    localparam logic [19:0] W_MIN = 20'(MIN_PULSE);
    localparam logic [19:0] W_MAX = 20'(MAX_PULSE);
    localparam logic [19:0] W_CPD = 20'(CYC_PER_DEG);
    localparam logic [22:0] P_MIN = 23'(MIN_PERIOD);
    localparam logic [22:0] P_MAX = 23'(MAX_PERIOD);
    localparam logic [21:0] P_TO  = 22'(TIMEOUT);
    localparam logic [8:0]  A_MAX = 9'(MAX_ANGLE);

    logic w_rise, w_fall;
    logic [22:0] w_per_len;
    state_t r_state;
    logic [19:0] r_width, r_rem;
    logic [8:0] r_q;
    logic [21:0] r_per;
    logic r_ref, r_wait;

    pwm_sync_edge u_sync (
        .clk(clk),
        .clr(clr),
        .i_async(pwm_in),
        .o_rise(w_rise),
        .o_fall(w_fall)
    );

    // rise-to-rise distance: the counter is zeroed on the rise cycle itself
    assign w_per_len = {1'b0, r_per} + 23'd1;
    assign busy = (r_state == HIGH) || (r_state == DIV);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_per       <= '0;
            r_ref       <= 1'b0;
            period_err  <= 1'b0;
            signal_lost <= 1'b0;
        end else if (w_rise) begin
            r_per       <= '0;
            r_ref       <= 1'b1;
            signal_lost <= 1'b0;
            if (r_state == DIV || r_state == VALID) period_err <= 1'b1;
            else if (r_ref) period_err <= (w_per_len < P_MIN) || (w_per_len > P_MAX);
        end else if (r_per != P_TO) begin
            r_per <= r_per + 22'd1;
            if (r_per == P_TO - 22'd1) begin
                signal_lost <= 1'b1;
                r_ref       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state     <= IDLE;
            r_width     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_wait      <= 1'b0;
            angle       <= '0;
            angle_valid <= 1'b0;
            pulse_width <= '0;
            width_err   <= 1'b0;
        end else begin
            angle_valid <= 1'b0;
            if (w_fall) r_wait <= 1'b0;
            case (r_state)
                IDLE: if (w_rise && !r_wait) begin
                    r_state <= HIGH;
                    r_width <= 20'd1;
                end
                HIGH: if (w_fall) begin
                    if (r_width >= W_MIN && r_width <= W_MAX) begin
                        r_state <= DIV;
                        r_rem   <= r_width - W_MIN;
                        r_q     <= '0;
                    end else begin
                        r_state   <= IDLE;
                        width_err <= 1'b1;
                    end
                end else if (r_width >= W_MAX) begin
                    // overlong pulse: abort now, ignore edges until it ends
                    r_state   <= IDLE;
                    width_err <= 1'b1;
                    r_wait    <= 1'b1;
                end else r_width <= r_width + 20'd1;
                DIV: if (r_rem >= W_CPD) begin
                    r_rem <= r_rem - W_CPD;
                    r_q   <= (r_q == 9'h1ff) ? r_q : r_q + 9'd1;
                end else r_state <= VALID;
                VALID: begin
                    angle       <= (r_q > A_MAX) ? A_MAX : r_q;
                    pulse_width <= r_width;
                    width_err   <= 1'b0;
                    angle_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: directed and random servo frames on a time-scaled
// decoder, checked against an arithmetic frame-level model.
module tb_servo_pwm_decoder;
    localparam int MINP = 100, MAXP = 500, CPD = 2, MINPER = 1900, MAXPER = 2100, TO = 2500;

    logic clk = 1'b0, clr = 1'b0, pwm_in = 1'b0;
    logic [8:0] angle;
    logic [19:0] pulse_width;
    logic angle_valid, width_err, period_err, signal_lost, busy;
    int vectors = 0, miscompares = 0;
    int cyc = 0, n_strobe = 0, strobe_cyc = 0;
    int exp_angle = 0, exp_pw = 0, exp_werr = 0, exp_perr = 0, prev_p = 0;
    bit ref_ok = 1'b0;

    servo_pwm_decoder #(
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .CYC_PER_DEG(CPD),
        .MIN_PERIOD(MINPER), .MAX_PERIOD(MAXPER), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .clr(clr), .pwm_in(pwm_in),
        .angle(angle), .angle_valid(angle_valid), .pulse_width(pulse_width),
        .width_err(width_err), .period_err(period_err),
        .signal_lost(signal_lost), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (angle_valid) begin
        n_strobe++;
        strobe_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " angle"}, 32'(angle), 0);
        check({tag, " angle_valid"}, 32'(angle_valid), 0);
        check({tag, " pulse_width"}, 32'(pulse_width), 0);
        check({tag, " width_err"}, 32'(width_err), 0);
        check({tag, " period_err"}, 32'(period_err), 0);
        check({tag, " signal_lost"}, 32'(signal_lost), 0);
        check({tag, " busy"}, 32'(busy), 0);
    endtask

    function automatic int exp_q(input int w);
        return (w - MINP) / CPD;
    endfunction

    // Called at a negedge; pin is high for w clocks of a p-clock frame.
    task automatic frame(input int w, input int p, input bit chk_per);
        int n0, rc, q;
        n0 = n_strobe;
        if (ref_ok) exp_perr = (prev_p < MINPER || prev_p > MAXPER) ? 1 : 0;
        ref_ok = 1'b1;
        prev_p = p;
        pwm_in = 1'b1;
        rc = cyc;
        repeat (w) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - w) @(negedge clk);
        if (w >= MINP && w <= MAXP) begin
            q = exp_q(w);
            exp_angle = (q > 180) ? 180 : q;
            exp_pw = w;
            exp_werr = 0;
            check("strobe count", 32'(n_strobe - n0), 1);
            // 2 sync stages to see fall, then q+2 cycles of divide/valid
            check("strobe latency", 32'(strobe_cyc - rc), 32'(w + q + 5));
        end else begin
            exp_werr = 1;
            check("strobe count", 32'(n_strobe - n0), 0);
        end
        check("angle", 32'(angle), 32'(exp_angle));
        check("pulse_width", 32'(pulse_width), 32'(exp_pw));
        check("width_err", 32'(width_err), 32'(exp_werr));
        if (chk_per) check("period_err", 32'(period_err), 32'(exp_perr));
        check("signal_lost", 32'(signal_lost), 0);
    endtask

    initial begin
        int w, p, c0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        clr = 1'b1;
        @(negedge clk);
        repeat (3) frame(100, 2000, 1);
        frame(280, 2000, 1);
        frame(500, 2000, 1);
        frame(80, 2000, 1);
        frame(520, 2000, 1);
        frame(200, 2000, 1);
        frame(150, 1000, 1);
        frame(300, 2000, 1);
        frame(300, 2000, 1);
        frame(101, 1900, 1);
        frame(499, 2100, 1);
        frame(501, 2101, 1);
        frame(250, 1899, 1);
        frame(250, 2000, 1);
        frame(99, 2000, 1);
        for (int i = 0; i < 12; i++) begin
            w = int'($urandom_range(60, 560));
            p = int'($urandom_range(1700, 2300));
            frame(w, p, 1);
        end
        // loss of signal: one frame, then pin stays low
        if (ref_ok) exp_perr = (prev_p < MINPER || prev_p > MAXPER) ? 1 : 0;
        pwm_in = 1'b1;
        c0 = cyc;
        repeat (300) @(negedge clk);
        pwm_in = 1'b0;
        repeat (TO + 2 - 300) @(negedge clk);
        check("lost before timeout", 32'(signal_lost), 0);
        check("lost cycle count", 32'(cyc - c0), 32'(TO + 2));
        @(negedge clk);
        check("lost at timeout", 32'(signal_lost), 1);
        check("lost frame angle", 32'(angle), 32'(exp_q(300)));
        check("lost period_err", 32'(period_err), 32'(exp_perr));
        exp_angle = exp_q(300);
        exp_pw = 300;
        exp_werr = 0;
        ref_ok = 1'b0;
        repeat (50) @(negedge clk);
        frame(200, 2000, 1);
        frame(220, 2100, 1);
        frame(240, 2000, 1);
        // reset in the middle of a high pulse
        pwm_in = 1'b1;
        c0 = n_strobe;
        repeat (200) @(negedge clk);
        check("busy mid-high", 32'(busy), 1);
        clr = 1'b0;
        @(negedge clk);
        check_zero("mid-frame reset");
        clr = 1'b1;
        exp_angle = 0;
        exp_pw = 0;
        exp_werr = 0;
        exp_perr = 0;
        ref_ok = 1'b0;
        repeat (20) @(negedge clk);
        pwm_in = 1'b0;
        repeat (1780) @(negedge clk);
        check("no strobe after reset", 32'(n_strobe - c0), 0);
        check("angle after reset", 32'(angle), 0);
        check("pulse_width after reset", 32'(pulse_width), 0);
        frame(300, 2000, 0);
        frame(260, 2000, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
